// File: rtl/axilite_noc_width_gearbox.sv
// Valid/ready width gearbox: packs narrow beats into wide words (upsize), splits wide
// words into narrow slices (downsize), or acts as a one-entry register slice (equal widths).
module axilite_noc_width_gearbox #(
  parameter int DATA_INPUT_WIDTH  = 64,
  parameter int DATA_OUTPUT_WIDTH = 512,
  localparam int RATIO = ((DATA_OUTPUT_WIDTH > DATA_INPUT_WIDTH) ? DATA_OUTPUT_WIDTH : DATA_INPUT_WIDTH) /
                         ((DATA_OUTPUT_WIDTH > DATA_INPUT_WIDTH) ? DATA_INPUT_WIDTH : DATA_OUTPUT_WIDTH),
  localparam int CW = $clog2(RATIO) + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         inp_valid,
  output logic                         inp_ready,
  input  logic [DATA_INPUT_WIDTH-1:0]  inp_data,
  input  logic                         inp_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_OUTPUT_WIDTH-1:0] out_data,
  output logic                         out_last,
  output logic [CW-1:0]                out_beats
);

  if ((DATA_INPUT_WIDTH % 8) != 0 || (DATA_OUTPUT_WIDTH % 8) != 0) begin : g_bad_byte_width
    $error("axilite_noc_width_gearbox: widths must be multiples of 8");
  end

  if ((DATA_OUTPUT_WIDTH > DATA_INPUT_WIDTH && (DATA_OUTPUT_WIDTH % DATA_INPUT_WIDTH) != 0) ||
      (DATA_INPUT_WIDTH > DATA_OUTPUT_WIDTH && (DATA_INPUT_WIDTH % DATA_OUTPUT_WIDTH) != 0)) begin : g_bad_ratio
    $error("axilite_noc_width_gearbox: wider width must be an integer multiple of the narrower");
  end

  if (DATA_OUTPUT_WIDTH > DATA_INPUT_WIDTH) begin : g_up
    logic [DATA_OUTPUT_WIDTH-1:0] r_acc;
    logic [DATA_OUTPUT_WIDTH-1:0] r_out_data;
    logic [DATA_OUTPUT_WIDTH-1:0] w_acc_next;
    logic [CW-1:0]                r_cnt;
    logic [CW-1:0]                r_out_beats;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic                         w_inp_ready;
    logic                         w_in_fire;
    logic                         w_out_fire;
    logic                         w_complete;

    // Only the slot addressed by r_cnt takes the new beat; the rest keep their contents.
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slot
      assign w_acc_next[gi*DATA_INPUT_WIDTH +: DATA_INPUT_WIDTH] =
        (r_cnt == CW'(gi)) ? inp_data : r_acc[gi*DATA_INPUT_WIDTH +: DATA_INPUT_WIDTH];
    end

    assign w_inp_ready = !rst && (!r_out_valid || out_ready);
    assign w_in_fire   = inp_valid && w_inp_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_complete  = (r_cnt == CW'(RATIO - 1)) || inp_last;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
        r_out_beats <= '0;
      end else begin
        if (w_out_fire) begin
          r_out_valid <= 1'b0;
        end
        if (w_in_fire) begin
          if (w_complete) begin
            // Accumulator restarts zeroed so a following partial word has empty upper slots.
            r_out_data  <= w_acc_next;
            r_out_valid <= 1'b1;
            r_out_beats <= r_cnt + CW'(1);
            r_out_last  <= inp_last;
            r_acc       <= '0;
            r_cnt       <= '0;
          end else begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end

    assign inp_ready = w_inp_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_beats = r_out_beats;

  end else if (DATA_INPUT_WIDTH > DATA_OUTPUT_WIDTH) begin : g_down
    localparam int IW = $clog2(RATIO);

    logic [DATA_INPUT_WIDTH-1:0]  r_hold;
    logic                         r_hold_last;
    logic [CW-1:0]                r_cnt;
    logic                         r_out_valid;
    logic [DATA_OUTPUT_WIDTH-1:0] w_slice [RATIO];
    logic                         w_final_slice;
    logic                         w_inp_ready;
    logic                         w_in_fire;
    logic                         w_out_fire;

    for (genvar gi = 0; gi < RATIO; gi++) begin : g_slice
      assign w_slice[gi] = r_hold[gi*DATA_OUTPUT_WIDTH +: DATA_OUTPUT_WIDTH];
    end

    assign w_final_slice = (r_cnt == CW'(RATIO - 1));
    // A new word may only enter as the last slice of the held word leaves.
    assign w_inp_ready   = !rst && (!r_out_valid || (out_ready && w_final_slice));
    assign w_in_fire     = inp_valid && w_inp_ready;
    assign w_out_fire    = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_hold      <= '0;
        r_hold_last <= 1'b0;
        r_cnt       <= '0;
        r_out_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_hold      <= inp_data;
        r_hold_last <= inp_last;
        r_cnt       <= '0;
        r_out_valid <= 1'b1;
      end else if (w_out_fire) begin
        if (w_final_slice) begin
          r_cnt       <= '0;
          r_out_valid <= 1'b0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end

    assign inp_ready = w_inp_ready;
    assign out_valid = r_out_valid;
    assign out_data  = w_slice[r_cnt[IW-1:0]];
    assign out_last  = r_hold_last && w_final_slice;
    assign out_beats = CW'(!rst);

  end else begin : g_equal
    logic [DATA_OUTPUT_WIDTH-1:0] r_out_data;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic                         w_inp_ready;
    logic                         w_in_fire;
    logic                         w_out_fire;

    assign w_inp_ready = !rst && (!r_out_valid || out_ready);
    assign w_in_fire   = inp_valid && w_inp_ready;
    assign w_out_fire  = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_out_data  <= '0;
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end else if (w_in_fire) begin
        r_out_data  <= inp_data;
        r_out_valid <= 1'b1;
        r_out_last  <= inp_last;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end

    assign inp_ready = w_inp_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_beats = CW'(!rst);
  end

endmodule
